// File: rtl/ps2_pkg.sv
// PS/2 shared definitions: FSM encoding, register offsets, frame builder.
// Used by the host transmitter and the keyboard receiver.
package ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INHIBIT,
    ST_START,
    ST_SHIFT,
    ST_ACK,
    ST_WAITIDLE
  } ps2_state_t;

  localparam logic REG_STAT = 1'b0;
  localparam logic REG_DATA = 1'b1;

  localparam logic [3:0] FRAME_BITS = 4'd10;

  // Bits shifted after the start bit: data LSB first, odd parity, stop.
  function automatic logic [9:0] tx_frame(input logic [7:0] d);
    return {1'b1, ~^d, d};
  endfunction

endpackage

// File: rtl/ps2_sync.sv
// Two-flop synchronizer for one PS/2 line plus falling-edge detect.
// Flops reset high so an idle bus never looks like an edge.
module ps2_sync (
  input  logic clk,
  input  logic reset,
  input  logic i_line,
  output logic o_level,
  output logic o_fall
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
      r_prev <= 1'b1;
    end else begin
      r_meta <= i_line;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign o_level = r_sync;
  assign o_fall  = r_prev & ~r_sync;

endmodule

// File: rtl/ps2_tx.sv
// PS/2 host-to-device transmitter with a two-register bus interface.
// Inhibits the clock, sends start/data/parity/stop, checks device ACK.
module ps2_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       wr,
  input  logic       addr2,
  input  logic [7:0] data_in,
  output logic [7:0] data_out,
  output logic       wt,
  output logic       irq,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_low,
  output logic       ps2_data_low
);

  localparam int IW = $clog2(INHIBIT_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  ps2_state_t  r_state;
  logic [7:0]  r_data;
  logic        r_ien;
  logic        r_err;
  logic        r_ack;
  logic        r_clk_low;
  logic        r_data_low;
  logic [IW-1:0] r_inh;
  logic [TW-1:0] r_tmo;
  logic [3:0]  r_bit;

  logic       w_clk_lvl;
  logic       w_clk_fall;
  logic       w_data_lvl;
  logic       w_data_fall;
  logic       w_rdy;
  logic       w_wr_stat;
  logic       w_wr_data;
  logic       w_active;
  logic       w_tmo_hit;
  logic       w_ack_seen;
  logic [9:0] w_frame;

  ps2_sync u_sync_clk (
    .clk     (clk),
    .reset   (reset),
    .i_line  (ps2_clk_in),
    .o_level (w_clk_lvl),
    .o_fall  (w_clk_fall)
  );

  ps2_sync u_sync_data (
    .clk     (clk),
    .reset   (reset),
    .i_line  (ps2_data_in),
    .o_level (w_data_lvl),
    .o_fall  (w_data_fall)
  );

  assign w_rdy      = (r_state == ST_IDLE);
  assign w_wr_stat  = en & wr & (addr2 == REG_STAT);
  assign w_wr_data  = en & wr & (addr2 == REG_DATA);
  assign w_active   = (r_state == ST_START) || (r_state == ST_SHIFT) ||
                      (r_state == ST_ACK) || (r_state == ST_WAITIDLE);
  assign w_tmo_hit  = (r_tmo == TW'(TIMEOUT_CYCLES - 1));
  assign w_ack_seen = ~w_data_lvl | w_data_fall;
  assign w_frame    = tx_frame(r_data);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_data     <= 8'h00;
      r_ien      <= 1'b0;
      r_err      <= 1'b0;
      r_ack      <= 1'b0;
      r_clk_low  <= 1'b0;
      r_data_low <= 1'b0;
      r_inh      <= '0;
      r_tmo      <= '0;
      r_bit      <= '0;
    end else begin
      if (w_wr_stat)
        r_ien <= data_in[1];
      if (w_active && w_tmo_hit) begin
        r_state    <= ST_IDLE;
        r_clk_low  <= 1'b0;
        r_data_low <= 1'b0;
        r_err      <= 1'b1;
      end else begin
        unique case (r_state)
          ST_IDLE: begin
            if (w_wr_data) begin
              r_data     <= data_in;
              r_err      <= 1'b0;
              r_ack      <= 1'b0;
              r_inh      <= '0;
              r_clk_low  <= 1'b1;
              r_data_low <= (INHIBIT_CYCLES == 1);
              r_state    <= ST_INHIBIT;
            end
          end
          ST_INHIBIT: begin
            r_inh <= r_inh + 1'b1;
            if (r_inh == IW'(INHIBIT_CYCLES - 2))
              r_data_low <= 1'b1;
            if (r_inh == IW'(INHIBIT_CYCLES - 1)) begin
              r_clk_low  <= 1'b0;
              r_data_low <= 1'b1;
              r_tmo      <= '0;
              r_state    <= ST_START;
            end
          end
          ST_START: begin
            r_tmo <= r_tmo + 1'b1;
            if (w_clk_fall) begin
              r_data_low <= ~w_frame[0];
              r_bit      <= 4'd1;
              r_state    <= ST_SHIFT;
            end
          end
          ST_SHIFT: begin
            r_tmo <= r_tmo + 1'b1;
            if (w_clk_fall) begin
              // r_bit is the next frame index; all ten sent means ACK slot.
              if (r_bit == FRAME_BITS) begin
                r_data_low <= 1'b0;
                r_state    <= ST_ACK;
                if (w_ack_seen)
                  r_ack <= 1'b1;
                else
                  r_err <= 1'b1;
              end else begin
                r_data_low <= ~w_frame[r_bit];
                r_bit      <= r_bit + 1'b1;
              end
            end
          end
          ST_ACK: begin
            r_tmo   <= r_tmo + 1'b1;
            r_state <= ST_WAITIDLE;
          end
          ST_WAITIDLE: begin
            r_tmo <= r_tmo + 1'b1;
            if (w_clk_lvl && w_data_lvl)
              r_state <= ST_IDLE;
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign data_out     = (addr2 == REG_DATA) ? r_data
                      : {4'b0, r_ack, r_err, r_ien, w_rdy};
  assign wt           = 1'b0;
  assign irq          = w_rdy & r_ien;
  assign ps2_clk_low  = r_clk_low;
  assign ps2_data_low = r_data_low;

endmodule
